// File: rtl/des_pkg.sv
// Shared DES key-schedule helpers: PC-1/PC-2 permutations, parity check,
// per-round shift table and FSM state encoding (used by encrypt and decrypt schedules).
package des_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_EMIT   = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  // Left-shift amount applied before round n+1 in the encrypt direction.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Tables hold DES bit numbers (1 = MSB) in output order.
  localparam logic [5:0] PC1_C_T [28] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
    6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
    6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
    6'd60, 6'd52, 6'd44, 6'd36
  };

  localparam logic [5:0] PC1_D_T [28] = '{
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,
    6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6,
    6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
    6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_T [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [27:0] pc1_c(input logic [63:0] k);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < 28; i++)
      r[5'(27 - i)] = k[6'(7'd64 - 7'(PC1_C_T[i]))];
    return r;
  endfunction

  function automatic logic [27:0] pc1_d(input logic [63:0] k);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < 28; i++)
      r[5'(27 - i)] = k[6'(7'd64 - 7'(PC1_D_T[i]))];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[6'(47 - i)] = cd[6'(7'd56 - 7'(PC2_T[i]))];
    return r;
  endfunction

  // Every byte must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++)
      ok = ok & (^(8'(k >> (8 * b))));
    return ok;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] h, input logic [1:0] n);
    return (n == 2'd1) ? {h[0], h[27:1]} : {h[1:0], h[27:2]};
  endfunction

endpackage

// File: rtl/des_keygen_dec.sv
// Decrypt-direction DES key schedule: emits K16..K1 over a valid/ready handshake,
// deriving each subkey by right-rotating the C/D halves in place.
module des_keygen_dec
  import des_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [47:0] Kn,
  output logic [3:0]  kn_idx,
  output logic        busy,
  output logic        done,
  output logic        key_err
);

  state_t      state_q, state_d;
  logic [63:0] key_q, key_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  kn_idx_q, kn_idx_d;
  logic        handshake;
  logic        parity_fail;

  assign handshake   = (state_q == ST_EMIT) && out_ready;
  assign parity_fail = CHECK_PARITY && !odd_parity_ok(key_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset branch is asynchronous and listed in the sensitivity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: each always_comb assigns its outputs a default first so no path
  // leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   state_d = parity_fail ? ST_IDLE : ST_EMIT;
      ST_EMIT:   if (handshake && (kn_idx_q == 4'd0)) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // C16D16 equals C0D0, so K16 comes straight from PC-1 and later rounds rotate right.
  always_comb begin
    key_d    = key_q;
    cd_d     = cd_q;
    kn_idx_d = kn_idx_q;
    unique case (state_q)
      ST_IDLE: if (start) key_d = key;
      ST_LOAD: begin
        if (!parity_fail) begin
          cd_d     = {pc1_c(key_q), pc1_d(key_q)};
          kn_idx_d = 4'd15;
        end
      end
      ST_EMIT: begin
        if (handshake && (kn_idx_q != 4'd0)) begin
          cd_d     = {rotr28(cd_q[55:28], SHIFT[kn_idx_q]),
                      rotr28(cd_q[27:0],  SHIFT[kn_idx_q])};
          kn_idx_d = kn_idx_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q    <= '0;
      cd_q     <= '0;
      kn_idx_q <= '0;
    end else begin
      key_q    <= key_d;
      cd_q     <= cd_d;
      kn_idx_q <= kn_idx_d;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    key_err   = 1'b0;
    unique case (state_q)
      ST_IDLE:   ;
      ST_LOAD:   begin busy = 1'b1; key_err = parity_fail; end
      ST_EMIT:   begin busy = 1'b1; out_valid = 1'b1; end
      ST_FINISH: begin busy = 1'b1; done = 1'b1; end
      default:   ;
    endcase
  end

  assign Kn     = pc2(cd_q);
  assign kn_idx = kn_idx_q;

endmodule

// File: tb/tb_des_keygen_dec.sv
// Self-checking bench for des_keygen_dec: two instances (parity check off/on) driven
// in parallel and compared every cycle against a forward-schedule reference model.
module tb_des_keygen_dec;

  localparam logic [63:0] TEST_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] BAD_KEY  = 64'h133457799BBCDFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic        out_ready = 1'b0;

  logic        ov0, bz0, dn0, er0, ov1, bz1, dn1, er1;
  logic [47:0] kn0, kn1;
  logic [3:0]  idx0, idx1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  des_keygen_dec #(.CHECK_PARITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key(key), .out_ready(out_ready),
    .out_valid(ov0), .Kn(kn0), .kn_idx(idx0), .busy(bz0), .done(dn0), .key_err(er0));

  des_keygen_dec #(.CHECK_PARITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .key(key), .out_ready(out_ready),
    .out_valid(ov1), .Kn(kn1), .kn_idx(idx1), .busy(bz1), .done(dn1), .key_err(er1));

  // ---------------- reference model (forward FIPS-46 schedule) ----------------
  int pc1c_t [28] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36};
  int pc1d_t [28] = '{63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t  [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                      41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int lshift [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Encrypt subkey K_n (n = 1..16): C0/D0 rotated left by the cumulative shift, then PC-2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int n);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] r;
    int total;
    c = '0; d = '0; r = '0; total = 0;
    for (int i = 0; i < 28; i++) begin
      c = {c[26:0], 1'(k >> (64 - pc1c_t[i]))};
      d = {d[26:0], 1'(k >> (64 - pc1d_t[i]))};
    end
    for (int i = 0; i < n; i++) total += lshift[i];
    for (int s = 0; s < total; s++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r = {r[46:0], 1'(cd >> (56 - pc2_t[i]))};
    return r;
  endfunction

  function automatic bit ref_par_ok(input logic [63:0] k);
    for (int b = 0; b < 8; b++)
      if ($countones(8'(k >> (8 * b))) % 2 == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Model phase per instance: 0 idle, 1 load, 2 emitting, 3 finished.
  int          m_ph  [2];
  int          m_idx [2];
  logic [63:0] m_key [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_ph[d]  <= 0;
        m_idx[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        case (m_ph[d])
          0: if (start) begin m_ph[d] <= 1; m_key[d] <= key; end
          1: if (d == 1 && !ref_par_ok(m_key[d])) m_ph[d] <= 0;
             else begin m_ph[d] <= 2; m_idx[d] <= 15; end
          2: if (out_ready) begin
               if (m_idx[d] == 0) m_ph[d] <= 3;
               else m_idx[d] <= m_idx[d] - 1;
             end
          default: m_ph[d] <= 0;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic ov, input logic [47:0] kn, input logic [3:0] idx,
                         input logic bz, input logic dn, input logic er);
    bit exp_err;
    exp_err = (m_ph[d] == 1) && (d == 1) && !ref_par_ok(m_key[d]);
    check($sformatf("dut%0d.out_valid", d), 64'(ov), 64'(m_ph[d] == 2));
    check($sformatf("dut%0d.busy", d),      64'(bz), 64'(m_ph[d] != 0));
    check($sformatf("dut%0d.done", d),      64'(dn), 64'(m_ph[d] == 3));
    check($sformatf("dut%0d.key_err", d),   64'(er), 64'(exp_err));
    if (m_ph[d] == 2) begin
      // Decrypt position kn_idx carries encrypt subkey K(kn_idx+1).
      check($sformatf("dut%0d.Kn", d),     64'(kn),  64'(ref_subkey(m_key[d], m_idx[d] + 1)));
      check($sformatf("dut%0d.kn_idx", d), 64'(idx), 64'(m_idx[d]));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp_dut(0, ov0, kn0, idx0, bz0, dn0, er0);
      cmp_dut(1, ov1, kn1, idx1, bz1, dn1, er1);
    end
  end

  // Event counters; tests read differences across a window.
  int hs0_cnt = 0, done0_cnt = 0, err1_cnt = 0, ov1_cnt = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (ov0 && out_ready) hs0_cnt++;
      if (dn0) done0_cnt++;
      if (er1) err1_cnt++;
      if (ov1) ov1_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while ((bz0 || bz1) && n < 600) begin
      @(posedge clk);
      n++;
    end
    check("wait_idle_timeout", 64'(n >= 600), 64'(0));
  endtask

  task automatic do_sched(input logic [63:0] k, input bit rand_ready);
    int n = 0;
    wait_idle();
    @(posedge clk); #1;
    key = k;
    start = 1'b1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while ((bz0 || bz1) && n < 600) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("sched_timeout", 64'(n >= 600), 64'(0));
  endtask

  task automatic literal_sched(input string tag);
    wait_idle();
    @(posedge clk); #1;
    key = TEST_KEY; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;            // start accepted at this edge (cycle t)
    start = 1'b0;
    @(posedge clk);                // LOAD -> EMIT
    @(negedge clk);                // cycle t+2
    check({tag, "_first_Kn"},  64'(kn0),  64'h0000CB3D8B0E17F5);
    check({tag, "_first_idx"}, 64'(idx0), 64'd15);
    check({tag, "_first_Kn_p"}, 64'(kn1), 64'h0000CB3D8B0E17F5);
    repeat (15) @(negedge clk);    // cycle t+17
    check({tag, "_last_Kn"},  64'(kn0),  64'h00001B02EFFC7072);
    check({tag, "_last_idx"}, 64'(idx0), 64'd0);
    @(negedge clk);                // cycle t+18
    check({tag, "_done"}, 64'(dn0), 64'd1);
    wait_idle();
  endtask

  initial begin
    int hs_a, dn_a, er_a, ov_a, n;
    logic [63:0] k;

    // Pin the reference model against known FIPS values.
    check("model_K16", 64'(ref_subkey(TEST_KEY, 16)), 64'h0000CB3D8B0E17F5);
    check("model_K1",  64'(ref_subkey(TEST_KEY, 1)),  64'h00001B02EFFC7072);
    check("model_par_good", 64'(ref_par_ok(TEST_KEY)), 64'd1);
    check("model_par_bad",  64'(ref_par_ok(BAD_KEY)),  64'd0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(ov0 | ov1), 64'd0);
    check("reset_busy",      64'(bz0 | bz1), 64'd0);
    check("reset_done",      64'(dn0 | dn1), 64'd0);
    check("reset_key_err",   64'(er0 | er1), 64'd0);
    check("reset_kn_idx",    64'(idx0),      64'd0);

    // 1: known key with out_ready high.
    literal_sched("t1");

    // 2: same key, random back-pressure.
    hs_a = hs0_cnt;
    do_sched(TEST_KEY, 1'b1);
    check("t2_handshakes", 64'(hs0_cnt - hs_a), 64'd16);

    // 3: bad-parity key.
    er_a = err1_cnt; ov_a = ov1_cnt; hs_a = hs0_cnt;
    do_sched(BAD_KEY, 1'b0);
    check("t3_key_err_pulses", 64'(err1_cnt - er_a), 64'd1);
    check("t3_no_valid",       64'(ov1_cnt - ov_a),  64'd0);
    check("t3_noparity_hs",    64'(hs0_cnt - hs_a),  64'd16);

    // 4: reset in the middle of EMIT.
    wait_idle();
    dn_a = done0_cnt;
    @(posedge clk); #1;
    key = TEST_KEY; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ov0 && idx0 == 4'd7) && n < 50);
    check("t4_reach_idx7", 64'(n >= 50), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_valid", 64'(ov0 | ov1), 64'd0);
    check("t4_rst_busy",  64'(bz0 | bz1), 64'd0);
    check("t4_rst_done",  64'(dn0 | dn1), 64'd0);
    check("t4_rst_err",   64'(er0 | er1), 64'd0);
    check("t4_rst_Kn",    64'(kn0 | kn1), 64'd0);
    check("t4_rst_idx",   64'(idx0 | idx1), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    check("t4_no_done", 64'(done0_cnt - dn_a), 64'd0);
    literal_sched("t4");

    // 5: start held high across three schedules.
    wait_idle();
    hs_a = hs0_cnt; dn_a = done0_cnt;
    @(posedge clk); #1;
    key = TEST_KEY; start = 1'b1; out_ready = 1'b1;
    n = 0;
    while ((done0_cnt - dn_a) < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (dn0 && (done0_cnt - dn_a) == 2) break;   // third done visible now
    end
    start = 1'b0;
    check("t5_timeout", 64'(n >= 200), 64'd0);
    wait_idle();
    check("t5_handshakes", 64'(hs0_cnt - hs_a), 64'd48);
    check("t5_dones",      64'(done0_cnt - dn_a), 64'd3);

    // 6: random keys; half of them forced to odd parity so both instances schedule.
    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom};
      if (i % 2 == 0)
        for (int b = 0; b < 8; b++)
          if ($countones(8'(k >> (8 * b))) % 2 == 0) k = k ^ (64'd1 << (8 * b));
      do_sched(k, i < 200);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
